jtag_host: RTL and testbench

JTAG_HOST -- requirements
Module: jtag_host

---
 rtl/jtag_pkg.sv | 27 ++
 rtl/jtag_tck_gen.sv | 50 +++++
 rtl/jtag_host.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_host.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG host state type, TMS walk sequences and limits
package jtag_pkg;

  typedef enum logic [2:0] {
    RESET_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } jtag_state_e;

  localparam int MAX_LEN          = 32;
  localparam int RESET_TMS_CYCLES = 5;

  // TMS walks from Run-Test/Idle into Shift-xR and back; bit 0 is driven first
  localparam logic [3:0] DR_PRE_TMS = 4'b0001;
  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam logic [5:0] DR_PRE_LEN = 6'd3;
  localparam logic [5:0] IR_PRE_LEN = 6'd4;
  localparam logic [1:0] POST_TMS   = 2'b01;

  function automatic logic len_ok(input logic [5:0] len);
    return (len != 6'd0) && (len <= 6'(MAX_LEN));
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with one-cycle fall/rise strobes
// Each period is CLK_DIV cycles low then CLK_DIV cycles high; TCK parks low when disabled.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic tck_fall_o,
  output logic tck_rise_o
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       wrap;

  always_comb begin
    wrap  = en_i && (cnt_q == DIV_M1);
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      tck_d = !tck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  // Strobes mark the cycle whose closing edge moves TCK
  assign tck_rise_o = wrap && !tck_q;
  assign tck_fall_o = wrap && tck_q;
  assign tck_o      = tck_q;

endmodule

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG scan host: IR/DR scans and TAP reset over TCK/TMS/TDI/TDO
// Define JTAG_HOST_TRST_EN to add the TRST_N output.
module jtag_host
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_IR,
  input  logic [5:0]  CMD_LEN,
  input  logic [31:0] CMD_DATA,
  input  logic        TAP_RESET,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic        TRST_N
`endif
);

  jtag_state_e state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        ir_q, ir_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cap_q, cap_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        tck_en, tck_fall, tck_rise;
  logic [5:0]  nxt_idx, pre_len;
  logic [3:0]  pre_tms;

  assign tck_en = (state_q == RESET_SEQ) || (state_q == PRE) ||
                  (state_q == SHIFT) || (state_q == POST);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (tck_en),
    .tck_o      (TCK),
    .tck_fall_o (tck_fall),
    .tck_rise_o (tck_rise)
  );

  // TMS/TDI for period n+1 are loaded on the edge that ends period n (TCK falling)
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ir_d        = ir_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    nxt_idx     = idx_q + 6'd1;
    pre_len     = ir_q ? IR_PRE_LEN : DR_PRE_LEN;
    pre_tms     = ir_q ? IR_PRE_TMS : DR_PRE_TMS;

    case (state_q)
      RESET_SEQ: begin
        if (tck_fall) begin
          if (idx_q == 6'(RESET_TMS_CYCLES)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = nxt_idx;
            tms_d = (nxt_idx < 6'(RESET_TMS_CYCLES));
          end
        end
      end
      IDLE: begin
        if (TAP_RESET) begin
          state_d = RESET_SEQ;
          idx_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else if (CMD_VALID) begin
          ir_d   = CMD_IR;
          len_d  = CMD_LEN;
          data_d = CMD_DATA;
          if (!len_ok(CMD_LEN)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = PRE;
            idx_d   = '0;
            tms_d   = CMD_IR ? IR_PRE_TMS[0] : DR_PRE_TMS[0];
            tdi_d   = 1'b0;
            cap_d   = '0;
          end
        end
      end
      PRE: begin
        if (tck_fall) begin
          if (idx_q == pre_len - 6'd1) begin
            state_d = SHIFT;
            idx_d   = '0;
            tms_d   = (len_q == 6'd1);
            tdi_d   = data_q[0];
          end else begin
            idx_d = nxt_idx;
            tms_d = pre_tms[nxt_idx[1:0]];
          end
        end
      end
      SHIFT: begin
        if (tck_rise) begin
          cap_d[idx_q[4:0]] = TDO;
        end
        if (tck_fall) begin
          if (idx_q == len_q - 6'd1) begin
            state_d = POST;
            idx_d   = '0;
            tms_d   = POST_TMS[0];
            tdi_d   = 1'b0;
          end else begin
            idx_d = nxt_idx;
            tms_d = (nxt_idx == len_q - 6'd1);
            tdi_d = data_q[nxt_idx[4:0]];
          end
        end
      end
      POST: begin
        if (tck_fall) begin
          if (idx_q == 6'd1) begin
            state_d = RESP;
          end else begin
            idx_d = nxt_idx;
            tms_d = POST_TMS[nxt_idx[0]];
          end
        end
      end
      RESP: begin
        // A rejected command already pulsed on entry; only completed scans pulse here
        state_d = IDLE;
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end
      end
      default: state_d = RESET_SEQ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RESET_SEQ;
      idx_q       <= '0;
      ir_q        <= 1'b0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ir_q        <= ir_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_DATA  = rsp_data_q;

`ifdef JTAG_HOST_TRST_EN
  assign TRST_N = !(RST || (state_q == RESET_SEQ));
`endif

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - self-checking bench for jtag_host with a TCK-period monitor and target model
module tb_jtag_host;

  localparam int CLK_DIV = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_IR = 1'b0;
  logic [5:0]  CMD_LEN = '0;
  logic [31:0] CMD_DATA = '0;
  logic        TAP_RESET = 1'b0;
  logic        TDO = 1'b0;
  logic        CMD_READY, RSP_VALID, RSP_ERR, TCK, TMS, TDI;
  logic [31:0] RSP_DATA;
`ifdef JTAG_HOST_TRST_EN
  logic        TRST_N;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tdo_mode = 0;
  int timing_bad = 0;
  int rsp_count = 0;
  int last_fall_cyc = 0;
  int last_rise_cyc = 0;
  bit have_fall = 0;
  logic tck_last = 1'b0, tms_last = 1'b1, tdi_last = 1'b0;
  bit q_tms[$];
  bit q_tdi[$];
  bit q_tdo[$];

  jtag_host #(.CLK_DIV(CLK_DIV)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_IR    (CMD_IR),
    .CMD_LEN   (CMD_LEN),
    .CMD_DATA  (CMD_DATA),
    .TAP_RESET (TAP_RESET),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .RSP_ERR   (RSP_ERR),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
`ifdef JTAG_HOST_TRST_EN
    ,
    .TRST_N    (TRST_N)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Period monitor and target: records TMS/TDI/TDO at each TCK rise, drives TDO at each fall
  always @(negedge CLK) begin
    if (RST || CMD_READY) have_fall = 0;
    if (TCK === 1'b1 && tck_last === 1'b0) begin
      q_tms.push_back(TMS);
      q_tdi.push_back(TDI);
      q_tdo.push_back(TDO);
      if (have_fall && (cyc - last_fall_cyc) != CLK_DIV) timing_bad++;
      last_rise_cyc = cyc;
    end else if (TCK === 1'b0 && tck_last === 1'b1) begin
      if ((cyc - last_rise_cyc) != CLK_DIV) timing_bad++;
      last_fall_cyc = cyc;
      have_fall = 1;
      case (tdo_mode)
        0:       TDO = 1'b0;
        1:       TDO = TDI;
        default: TDO = 1'($urandom_range(0, 1));
      endcase
    end
    if (TCK === 1'b1 && (TMS !== tms_last || TDI !== tdi_last)) timing_bad++;
    if (RSP_VALID === 1'b1) rsp_count++;
    tck_last = TCK;
    tms_last = TMS;
    tdi_last = TDI;
  end

  function automatic bit exp_tms(input bit ir, input int len, input int k);
    int pre = ir ? 4 : 3;
    if (k < pre) return (k == 0) || (ir && k == 1);
    if (k < pre + len) return (k == pre + len - 1);
    return (k == pre + len);
  endfunction

  function automatic bit exp_tdi(input bit ir, input int len, input logic [31:0] data, input int k);
    int pre = ir ? 4 : 3;
    if (k >= pre && k < pre + len) return data[k - pre];
    return 1'b0;
  endfunction

  task automatic clear_mon();
    q_tms.delete();
    q_tdi.delete();
    q_tdo.delete();
    timing_bad = 0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s: CMD_READY=%b want 1 within 400 cycles", name, CMD_READY);
    end
  endtask

  task automatic test_reset();
    bit [5:0] got;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({TCK, TMS, TDI, CMD_READY, RSP_VALID, RSP_ERR} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_outputs: tck/tms/tdi/ready/valid/err=%b want 010000",
               {TCK, TMS, TDI, CMD_READY, RSP_VALID, RSP_ERR});
    end
    checks++;
    if (RSP_DATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp_data: got %h want 0", RSP_DATA);
    end
    clear_mon();
    RST = 1'b0;
    @(negedge CLK);
    wait_ready("reset_seq_ready");
    got = '0;
    for (int i = 0; i < 6 && i < q_tms.size(); i++) got[i] = q_tms[i];
    checks++;
    if (q_tms.size() != 6 || got !== 6'b011111) begin
      errors++;
      $display("FAIL reset_seq_tms: periods=%0d tms=%b want 6 periods tms=011111 (lsb first)", q_tms.size(), got);
    end
    checks++;
    if (timing_bad != 0) begin
      errors++;
      $display("FAIL reset_seq_timing: violations=%0d want 0", timing_bad);
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (q_tms.size() != 6 || TCK !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_tck: periods=%0d tck=%b want 6 and 0", q_tms.size(), TCK);
    end
  endtask

  task automatic do_scan(input bit ir, input int len, input logic [31:0] data, input int mode, input bit pulse_tap);
    int n, pre, tms_bad, tdi_bad, exp_n;
    logic [31:0] exp_data;
    bit bad_len;
    pre = ir ? 4 : 3;
    bad_len = (len == 0) || (len > 32);
    wait_ready("scan_ready");
    tdo_mode = mode;
    clear_mon();
    CMD_IR = ir;
    CMD_LEN = len[5:0];
    CMD_DATA = data;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    CMD_DATA = $urandom();
    CMD_LEN = 6'($urandom());
    CMD_IR = 1'($urandom());
    checks++;
    if (CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL scan_ready_drop: CMD_READY=%b want 0 after accept", CMD_READY);
    end
    if (bad_len) begin
      checks++;
      if ({RSP_VALID, RSP_ERR} !== 2'b11 || RSP_DATA !== 32'h0) begin
        errors++;
        $display("FAIL len_err_rsp: len=%0d valid=%b err=%b data=%h want 1 1 0", len, RSP_VALID, RSP_ERR, RSP_DATA);
      end
      repeat (3 * CLK_DIV + 2) @(negedge CLK);
      checks++;
      if (q_tms.size() != 0 || TCK !== 1'b0) begin
        errors++;
        $display("FAIL len_err_tck: periods=%0d tck=%b want 0 and 0", q_tms.size(), TCK);
      end
      return;
    end
    if (pulse_tap) begin
      TAP_RESET = 1'b1;
      repeat (3) @(negedge CLK);
      TAP_RESET = 1'b0;
    end
    n = 0;
    while (RSP_VALID !== 1'b1 && n < 90 * CLK_DIV + 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (RSP_VALID !== 1'b1) begin
      errors++;
      $display("FAIL scan_rsp_timeout: RSP_VALID=%b want 1", RSP_VALID);
    end
    exp_data = '0;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       exp_data[i] = 1'b0;
        1:       exp_data[i] = data[i];
        default: exp_data[i] = (pre + i < q_tdo.size()) ? q_tdo[pre + i] : 1'bx;
      endcase
    end
    checks++;
    if (RSP_DATA !== exp_data || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL scan_rsp_data: ir=%0d len=%0d data=%h err=%b want %h err 0", ir, len, RSP_DATA, RSP_ERR, exp_data);
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL scan_ready_with_rsp: CMD_READY=%b want 1", CMD_READY);
    end
    exp_n = len + pre + 2;
    checks++;
    if (q_tms.size() != exp_n) begin
      errors++;
      $display("FAIL scan_periods: got %0d want %0d (ir=%0d len=%0d)", q_tms.size(), exp_n, ir, len);
    end
    tms_bad = 0;
    tdi_bad = 0;
    for (int k = 0; k < q_tms.size(); k++) begin
      if (q_tms[k] != exp_tms(ir, len, k)) tms_bad++;
      if (q_tdi[k] != exp_tdi(ir, len, data, k)) tdi_bad++;
    end
    checks++;
    if (tms_bad != 0 || tdi_bad != 0) begin
      errors++;
      $display("FAIL scan_tms_tdi: bad tms=%0d tdi=%0d want 0 0 (ir=%0d len=%0d)", tms_bad, tdi_bad, ir, len);
    end
    checks++;
    if (cyc - last_fall_cyc != 1) begin
      errors++;
      $display("FAIL scan_rsp_latency: got %0d cycles after last fall want 1", cyc - last_fall_cyc);
    end
    checks++;
    if (timing_bad != 0) begin
      errors++;
      $display("FAIL scan_tck_timing: violations=%0d want 0", timing_bad);
    end
    @(negedge CLK);
    checks++;
    if (RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL scan_rsp_pulse: RSP_VALID=%b want 0 one cycle later", RSP_VALID);
    end
  endtask

  task automatic test_dr_loopback();
    do_scan(1'b0, 8, 32'h0000_00A5, 1, 1'b0);
  endtask

  task automatic test_ir_tdo_zero();
    do_scan(1'b1, 5, 32'h0000_001F, 0, 1'b0);
  endtask

  task automatic test_len_error();
    do_scan(1'b0, 0, $urandom(), 0, 1'b0);
    do_scan(1'b1, 33, $urandom(), 0, 1'b0);
  endtask

  task automatic test_tap_priority();
    int base;
    bit [5:0] got;
    wait_ready("tap_pri_ready");
    base = rsp_count;
    clear_mon();
    TAP_RESET = 1'b1;
    CMD_VALID = 1'b1;
    CMD_IR = 1'b0;
    CMD_LEN = 6'd8;
    CMD_DATA = $urandom();
    @(negedge CLK);
    TAP_RESET = 1'b0;
    CMD_VALID = 1'b0;
    checks++;
    if (CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL tap_pri_ready_drop: CMD_READY=%b want 0", CMD_READY);
    end
    wait_ready("tap_pri_done");
    got = '0;
    for (int i = 0; i < 6 && i < q_tms.size(); i++) got[i] = q_tms[i];
    checks++;
    if (q_tms.size() != 6 || got !== 6'b011111) begin
      errors++;
      $display("FAIL tap_pri_seq: periods=%0d tms=%b want 6 periods tms=011111", q_tms.size(), got);
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (rsp_count != base || q_tms.size() != 6) begin
      errors++;
      $display("FAIL tap_pri_no_cmd: responses=%0d periods=%0d want 0 and 6", rsp_count - base, q_tms.size());
    end
  endtask

  task automatic test_abort();
    int base, n;
    wait_ready("abort_ready");
    base = rsp_count;
    clear_mon();
    tdo_mode = 2;
    CMD_IR = 1'b0;
    CMD_LEN = 6'd16;
    CMD_DATA = $urandom();
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    n = 0;
    while (q_tms.size() < 7 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (q_tms.size() < 7) begin
      errors++;
      $display("FAIL abort_reach_bit3: periods=%0d want 7", q_tms.size());
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (TCK !== 1'b0 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_tck: tck=%b valid=%b want 0 0", TCK, RSP_VALID);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_ready("abort_recover");
    repeat (3) @(negedge CLK);
    checks++;
    if (rsp_count != base) begin
      errors++;
      $display("FAIL abort_no_rsp: responses=%0d want 0", rsp_count - base);
    end
  endtask

  task automatic test_back_to_back();
    do_scan(1'b0, 32, $urandom(), 2, 1'b0);
    do_scan(1'b1, 1, $urandom(), 1, 1'b0);
    for (int t = 0; t < 16; t++) begin
      int len;
      bit ir;
      ir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0)
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63));
      else
        len = int'($urandom_range(1, 32));
      do_scan(ir, len, $urandom(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_dr_loopback();
    test_ir_tdo_zero();
    test_len_error();
    test_tap_priority();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
